// File: rtl/booth_seq_ctrl_if.sv
// Signal bundle between booth_seq_ctrl, its operand producer, its result consumer and the Booth datapath.
// master = environment side (producer/consumer/datapath), slave = the sequencer.
interface booth_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [WIDTH-1:0]     mul_in1;
  logic [WIDTH-1:0]     mul_in2;
  logic                 mul_load;
  logic [2*WIDTH-1:0]   mul_prod;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*WIDTH-1:0]   res;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, res_ready, mul_prod,
    input  in_ready, mul_in1, mul_in2, mul_load, res_valid, res, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready, mul_prod,
    output in_ready, mul_in1, mul_in2, mul_load, res_valid, res, busy
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequencer framing a radix-2 Booth multiplier datapath with operand and result valid/ready handshakes.
// Optional build macro BOOTH_ZERO_SKIP_EN: a zero operand bypasses the datapath and returns 0 from LOAD.
module booth_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  booth_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_res;
  logic               w_lastIter;
  logic               w_inReady;
  logic               w_mulLoad;
  logic               w_busy;
  logic               w_resValid;

`ifdef BOOTH_ZERO_SKIP_EN
  logic               w_zeroOp;
  assign w_zeroOp = (r_opa == '0) || (r_opb == '0);
`endif

  assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_mulLoad   = 1'b1;
    w_busy      = 1'b0;
    w_resValid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_inReady = 1'b1;
        if (bus.in_valid) w_nextState = S_LOAD;
      end
      S_LOAD: begin
        w_busy      = 1'b1;
        w_nextState = S_RUN;
`ifdef BOOTH_ZERO_SKIP_EN
        if (w_zeroOp) w_nextState = S_DONE;
`endif
      end
      // Only state where the datapath is released to iterate.
      S_RUN: begin
        w_busy    = 1'b1;
        w_mulLoad = 1'b0;
        if (w_lastIter) w_nextState = S_CAPT;
      end
      S_CAPT: begin
        w_busy      = 1'b1;
        w_nextState = S_DONE;
      end
      S_DONE: begin
        w_resValid = 1'b1;
        if (bus.res_ready) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_opa <= bus.in_a;
            r_opb <= bus.in_b;
          end
        end
        S_LOAD: begin
          r_cnt <= '0;
`ifdef BOOTH_ZERO_SKIP_EN
          if (w_zeroOp) r_res <= '0;
`endif
        end
        S_RUN:   r_cnt <= r_cnt + 1'b1;
        S_CAPT:  r_res <= bus.mul_prod;
        default: ;
      endcase
    end
  end

  assign bus.mul_in1   = r_opa;
  assign bus.mul_in2   = r_opb;
  assign bus.mul_load  = w_mulLoad;
  assign bus.in_ready  = w_inReady;
  assign bus.busy      = w_busy;
  assign bus.res_valid = w_resValid;
  assign bus.res       = r_res;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed self-checking bench for booth_seq_ctrl, with a behavioural radix-2 Booth datapath attached.
module tb_booth_seq_ctrl;

  localparam int WIDTH = 32;
`ifdef BOOTH_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 34;
`endif

  logic clk;
  logic rst;
  int   cycle;
  int   checks;
  int   errors;

  booth_seq_ctrl_if #(.WIDTH(WIDTH)) bus();

  booth_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle++;

  // Behavioural Booth datapath: reload while mul_load, else add/sub m then arithmetic shift {a,q,q1}.
  logic [WIDTH-1:0] dpA, dpM, dpQ, dpSum;
  logic             dpQ1;

  always_comb begin
    dpSum = dpA;
    case ({dpQ[0], dpQ1})
      2'b01:   dpSum = dpA + dpM;
      2'b10:   dpSum = dpA - dpM;
      default: dpSum = dpA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.mul_load) begin
      dpA  <= '0;
      dpM  <= bus.mul_in1;
      dpQ  <= bus.mul_in2;
      dpQ1 <= 1'b0;
    end else begin
      {dpA, dpQ, dpQ1} <= {dpSum[WIDTH-1], dpSum, dpQ};
    end
  end

  assign bus.mul_prod = {dpA, dpQ};

  task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] r, output bit timedOut);
    int n;
    int t0;
    timedOut = 1'b0;
    lat      = -1;
    r        = '0;
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      bus.in_valid = 1'b0;
      timedOut     = 1'b1;
      return;
    end
    @(negedge clk);
    t0           = cycle;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      timedOut = 1'b1;
      return;
    end
    lat = cycle - t0;
    r   = bus.res;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.mul_load !== 1'b1) begin errors++; $display("[TB] FAIL reset_mul_load: got %b expected 1", bus.mul_load); end
    checks++;
    if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
    checks++;
    if (bus.res !== 64'h0) begin errors++; $display("[TB] FAIL reset_res: got %h expected 0", bus.res); end
    checks++;
    if ({bus.mul_in1, bus.mul_in2} !== 64'h0) begin
      errors++; $display("[TB] FAIL reset_operands: got %h expected 0", {bus.mul_in1, bus.mul_in2});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_idle: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int lat; logic [63:0] r; bit to;
    bus.res_ready = 1'b1;
    runOp(32'd7, 32'hFFFF_FFFD, lat, r, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL basic_timeout: got timeout expected result"); end
    checks++;
    if (lat != 34) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 34", lat); end
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("[TB] FAIL basic_res: got %h expected ffffffffffffffeb", r); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_in_ready_done: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_in_ready_after: got %b expected 1", bus.in_ready); end
    checks++;
    if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_res_valid_after: got %b expected 0", bus.res_valid); end
  endtask

  task automatic test_large_signed();
    int lat; logic [63:0] r; bit to;
    bus.res_ready = 1'b1;
    runOp(32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, r, to);
    checks++;
    if (to || r !== 64'h3FFF_FFFF_0000_0001) begin
      errors++; $display("[TB] FAIL large_max_sq: got %h (timeout=%0d) expected 3fffffff00000001", r, to);
    end
    @(negedge clk);
    runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, r, to);
    checks++;
    if (to || r !== 64'h1) begin errors++; $display("[TB] FAIL large_neg1_sq: got %h (timeout=%0d) expected 1", r, to); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat; logic [63:0] r; bit to; int n;
    bus.res_ready = 1'b0;
    runOp(32'd9, 32'd9, lat, r, to);
    checks++;
    if (to || r !== 64'd81) begin errors++; $display("[TB] FAIL bp_first_res: got %h (timeout=%0d) expected 51", r, to); end
    bus.in_a     = 32'd3;
    bus.in_b     = 32'd4;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus.res !== 64'd81 || bus.res_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_hold[%0d]: got res=%h valid=%b expected res=51 valid=1", i, bus.res, bus.res_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release: got in_ready=%b res_valid=%b expected 1 0", bus.in_ready, bus.res_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_second_accept: got busy=%b in_ready=%b expected 1 0", bus.busy, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200 || bus.res !== 64'd12) begin
      errors++; $display("[TB] FAIL bp_second_res: got %h (waited %0d) expected c", bus.res, n);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_run_reset();
    int lat; logic [63:0] r; bit to; int n;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.in_a     = 32'd1234;
    bus.in_b     = 32'd5678;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (11) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.mul_load !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_in_run: got busy=%b mul_load=%b expected 1 0", bus.busy, bus.mul_load);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset_flags: got res_valid=%b busy=%b expected 0 0", bus.res_valid, bus.busy);
    end
    checks++;
    if (bus.mul_load !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_reset_ctrl: got mul_load=%b in_ready=%b expected 1 1", bus.mul_load, bus.in_ready);
    end
    checks++;
    if (bus.res !== 64'h0) begin errors++; $display("[TB] FAIL mid_reset_res: got %h expected 0", bus.res); end
    @(negedge clk);
    rst = 1'b1;
    runOp(32'd5, 32'd6, lat, r, to);
    checks++;
    if (to || r !== 64'd30 || lat != 34) begin
      errors++; $display("[TB] FAIL mid_after_res: got res=%h lat=%0d (timeout=%0d) expected 1e lat 34", r, lat, to);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_operand();
    int lat; logic [63:0] r; bit to;
    bus.res_ready = 1'b1;
    runOp(32'd0, 32'd12345, lat, r, to);
    checks++;
    if (to || r !== 64'h0) begin errors++; $display("[TB] FAIL zero_res: got %h (timeout=%0d) expected 0", r, to); end
    checks++;
    if (lat != ZERO_LAT) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected %0d", lat, ZERO_LAT); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] aVec [3];
    logic [31:0] bVec [3];
    logic [63:0] expVec [3];
    int          seen [3];
    aVec   = '{32'd2, 32'hFFFF_FFFC, 32'd100};
    bVec   = '{32'd3, 32'd5, 32'hFFFF_FF9C};
    expVec = '{64'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_D8F0};
    bus.res_ready = 1'b1;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int n;
          bus.in_a     = aVec[i];
          bus.in_b     = bVec[i];
          bus.in_valid = 1'b1;
          n = 0;
          while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
          end
          @(negedge clk);
        end
        bus.in_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 3; j++) begin
          int m;
          m = 0;
          while (!bus.res_valid && m < 200) begin
            @(negedge clk);
            m++;
          end
          seen[j] = cycle;
          checks++;
          if (m >= 200 || bus.res !== expVec[j]) begin
            errors++; $display("[TB] FAIL b2b_res[%0d]: got %h (waited %0d) expected %h", j, bus.res, m, expVec[j]);
          end
          if (j > 0) begin
            checks++;
            if (seen[j] - seen[j-1] != WIDTH + 4) begin
              errors++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected %0d", j, seen[j] - seen[j-1], WIDTH + 4);
            end
          end
          @(negedge clk);
        end
      end
    join
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    cycle         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_large_signed();
    test_backpressure();
    test_mid_run_reset();
    test_zero_operand();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
